// File: rtl/debouncer_events.sv
// debouncer_events: debounces a synchronized input into a clean level,
// one-cycle press/release pulses, a one-shot long-press pulse and a
// wrapping press counter. All outputs are registered on clk_in.
module debouncer_events #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               sig_in,
  output logic               clean_out,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_pulse,
  output logic [COUNT_W-1:0] press_count
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_t;

  state_t            state;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_fired;
  logic              rel_commit;

  // A release committing on this edge suppresses a coincident long-press.
  assign rel_commit = (state == RELEASE_PEND) && !sig_in && (db_cnt == DB_LAST);

  // Debounce FSM, hold timer and registered event pulses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      long_fired    <= 1'b0;
      clean_out     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= '0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      // Hold timer runs while the committed level is high; the press commit
      // below overrides it when a new press starts.
      if (clean_out) begin
        if (hold_cnt != HOLD_LAST) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        if ((hold_cnt == HOLD_LAST) && !long_fired && !rel_commit) begin
          long_pulse <= 1'b1;
          long_fired <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (sig_in) begin
            state  <= PRESS_PEND;
            db_cnt <= DB_W'(1);
          end
        end
        PRESS_PEND: begin
          if (!sig_in) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state       <= PRESSED;
            clean_out   <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + COUNT_W'(1);
            hold_cnt    <= '0;
            long_fired  <= 1'b0;
            db_cnt      <= '0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        PRESSED: begin
          if (!sig_in) begin
            state  <= RELEASE_PEND;
            db_cnt <= DB_W'(1);
          end
        end
        RELEASE_PEND: begin
          if (sig_in) begin
            state  <= PRESSED;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state         <= IDLE;
            clean_out     <= 1'b0;
            release_pulse <= 1'b1;
            db_cnt        <= '0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debouncer_events.sv
// tb_debouncer_events: directed scenarios plus random bursts, every cycle
// compared against a run-length reference model of the debouncer.
module tb_debouncer_events;

  localparam int unsigned D  = 4;
  localparam int unsigned L  = 20;
  localparam int unsigned CW = 2;

  logic          clk_in;
  logic          rst_in;
  logic          sig_in;
  logic          clean_out;
  logic          press_pulse;
  logic          release_pulse;
  logic          long_pulse;
  logic [CW-1:0] press_count;

  int n_cmp;
  int n_err;

  // Reference model state: committed level, length of the current run of
  // samples disagreeing with it, edges since the last press, press total.
  int m_level;
  int m_run;
  int m_age;
  int m_presses;
  int m_press;
  int m_release;
  int m_long;

  debouncer_events #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .COUNT_W        (CW)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .sig_in       (sig_in),
    .clean_out    (clean_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_level   = 0;
    m_run     = 0;
    m_age     = 0;
    m_presses = 0;
    m_press   = 0;
    m_release = 0;
    m_long    = 0;
  endtask

  // One clock edge sampling v: a change commits after D consecutive
  // disagreeing samples; long fires when a press reaches age L unless the
  // release commits on that very edge.
  task automatic model_edge(input int v);
    int was_high;
    was_high  = m_level;
    m_press   = 0;
    m_release = 0;
    m_long    = 0;
    if (was_high == 1 && m_age <= L) m_age++;
    if (v != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_run   = 0;
        m_level = v;
        if (v == 1) begin
          m_press = 1;
          m_presses++;
          m_age = 0;
        end else begin
          m_release = 1;
        end
      end
    end else begin
      m_run = 0;
    end
    if (was_high == 1 && m_age == L && m_release == 0) m_long = 1;
  endtask

  task automatic compare_all();
    check("clean_out", 32'(clean_out), 32'(m_level));
    check("press_pulse", 32'(press_pulse), 32'(m_press));
    check("release_pulse", 32'(release_pulse), 32'(m_release));
    check("long_pulse", 32'(long_pulse), 32'(m_long));
    check("press_count", 32'(press_count), 32'(m_presses % (1 << CW)));
  endtask

  task automatic step(input int v);
    sig_in = v[0];
    @(posedge clk_in);
    model_edge(v);
    #1;
    compare_all();
  endtask

  task automatic run(input int v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clean"}, 32'(clean_out), 32'd0);
    check({tag, "_press"}, 32'(press_pulse), 32'd0);
    check({tag, "_release"}, 32'(release_pulse), 32'd0);
    check({tag, "_long"}, 32'(long_pulse), 32'd0);
    check({tag, "_count"}, 32'(press_count), 32'd0);
  endtask

  initial begin
    int v;
    int len;
    n_cmp  = 0;
    n_err  = 0;
    sig_in = 1'b0;
    rst_in = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check_all_zero("reset");
    @(negedge clk_in);
    rst_in = 1'b0;

    // Clean press/release with long press.
    run(0, 10);
    run(1, 30);
    run(0, 12);
    check("count_after_clean", 32'(press_count), 32'd1);

    // Press bounce: first burst too short.
    run(1, 3);
    run(0, 1);
    run(1, 5);
    run(0, 8);

    // Short press: no long pulse.
    run(1, 10);
    run(0, 10);

    // Release glitch during the long hold.
    run(1, D + 14);
    run(0, 2);
    run(1, 15);
    run(0, 8);

    // Release commit coincident with the long-press edge.
    run(1, D + 16);
    run(0, D + 4);

    // More presses to wrap the 2-bit counter.
    for (int k = 0; k < 3; k++) begin
      run(1, 6);
      run(0, 6);
    end

    // Async reset in the middle of a press debounce window.
    run(0, 5);
    run(1, 2);
    #2;
    rst_in = 1'b1;
    #1;
    check_all_zero("async_rst");
    sig_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    run(1, D + 2);
    check("count_after_rst", 32'(press_count), 32'd1);
    run(0, 8);

    // Random bursts, mostly short runs to exercise bounce handling.
    v = 0;
    for (int s = 0; s < 250; s++) begin
      v = 1 - v;
      if ($urandom_range(0, 3) == 0) len = $urandom_range(D, D + L + 6);
      else len = $urandom_range(1, D + 1);
      run(v, len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
